// File: rtl/operand_entry_ctrl.sv
// Operand entry controller: digit-wise editing of two signed operands, write-back
// to the operand store, then start/wait/show handshaking with the arithmetic unit.
module operand_entry_ctrl #(
  parameter int MAX_MAG = 9999,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_c,
  input  logic          btn_u,
  input  logic          btn_d,
  input  logic          btn_l,
  input  logic          btn_r,
  input  logic          calc_done,
  output logic          mem_we,
  output logic          mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          calc_start,
  output logic [DW-1:0] edit_val,
  output logic [1:0]    cursor,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    EDIT_A = 3'd0,
    WR_A   = 3'd1,
    EDIT_B = 3'd2,
    WR_B   = 3'd3,
    START  = 3'd4,
    WAIT   = 3'd5,
    SHOW   = 3'd6
  } state_t;

  localparam logic signed [DW:0] LIM_P = (DW+1)'(MAX_MAG);
  localparam logic signed [DW:0] LIM_N = -LIM_P;

  state_t                r_state, w_state_nxt;
  logic signed [DW-1:0]  r_edit_val, w_edit_nxt;
  logic [1:0]            r_cursor, w_cursor_nxt;
  logic                  r_mem_we, r_mem_addr, r_calc_start;
  logic [DW-1:0]         r_mem_din;

  logic signed [DW:0]    w_ext, w_pow, w_inc, w_dec;
  logic                  w_wr_nxt;

  function automatic logic signed [DW:0] pow10(input logic [1:0] c);
    case (c)
      2'd0:    pow10 = (DW+1)'(1);
      2'd1:    pow10 = (DW+1)'(10);
      2'd2:    pow10 = (DW+1)'(100);
      default: pow10 = (DW+1)'(1000);
    endcase
  endfunction

  // One extra bit of headroom so the limit test never sees a wrapped sum.
  assign w_ext = {r_edit_val[DW-1], r_edit_val};
  assign w_pow = pow10(r_cursor);
  assign w_inc = w_ext + w_pow;
  assign w_dec = w_ext - w_pow;

  always_comb begin
    w_state_nxt  = r_state;
    w_edit_nxt   = r_edit_val;
    w_cursor_nxt = r_cursor;
    case (r_state)
      EDIT_A, EDIT_B: begin
        if (btn_c) begin
          if (r_state == EDIT_A) w_state_nxt = WR_A;
          else                   w_state_nxt = WR_B;
        end else if (btn_l) begin
          w_cursor_nxt = r_cursor + 2'd1;
        end else if (btn_r) begin
          w_cursor_nxt = r_cursor - 2'd1;
        end else if (btn_u) begin
          if (w_inc <= LIM_P) w_edit_nxt = w_inc[DW-1:0];
        end else if (btn_d) begin
          if (w_dec >= LIM_N) w_edit_nxt = w_dec[DW-1:0];
        end
      end
      WR_A: begin
        w_state_nxt  = EDIT_B;
        w_edit_nxt   = '0;
        w_cursor_nxt = '0;
      end
      WR_B:  w_state_nxt = START;
      START: w_state_nxt = WAIT;
      WAIT:  if (calc_done) w_state_nxt = SHOW;
      SHOW: begin
        if (btn_c) begin
          w_state_nxt  = EDIT_A;
          w_edit_nxt   = '0;
          w_cursor_nxt = '0;
        end
      end
      default: w_state_nxt = EDIT_A;
    endcase
  end

  assign w_wr_nxt = (w_state_nxt == WR_A) || (w_state_nxt == WR_B);

  // Strobes are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= EDIT_A;
      r_edit_val   <= '0;
      r_cursor     <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 1'b0;
      r_mem_din    <= '0;
      r_calc_start <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_edit_val   <= w_edit_nxt;
      r_cursor     <= w_cursor_nxt;
      r_mem_we     <= w_wr_nxt;
      r_mem_addr   <= (w_state_nxt == WR_B);
      r_mem_din    <= w_wr_nxt ? w_edit_nxt : '0;
      r_calc_start <= (w_state_nxt == START);
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;
  assign calc_start = r_calc_start;
  assign edit_val   = r_edit_val;
  assign cursor     = r_cursor;
  assign state      = r_state;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Bench for operand_entry_ctrl: directed scenarios plus randomized button/done traffic
// compared every cycle against an integer-level reference model.
module tb_operand_entry_ctrl;

  localparam int MAX_MAG = 9999;
  localparam int DW      = 16;

  localparam logic [4:0] BC = 5'b10000;
  localparam logic [4:0] BL = 5'b01000;
  localparam logic [4:0] BR = 5'b00100;
  localparam logic [4:0] BU = 5'b00010;
  localparam logic [4:0] BD = 5'b00001;
  localparam logic [4:0] B0 = 5'b00000;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_c, btn_u, btn_d, btn_l, btn_r, calc_done;
  logic          mem_we, mem_addr, calc_start;
  logic [DW-1:0] mem_din, edit_val;
  logic [1:0]    cursor;
  logic [2:0]    state;

  int n_chk = 0;
  int n_err = 0;

  // reference model: state code, signed operand value, digit position
  int ms  = 0;
  int ev  = 0;
  int cur = 0;

  operand_entry_ctrl #(.MAX_MAG(MAX_MAG), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_c      (btn_c),
    .btn_u      (btn_u),
    .btn_d      (btn_d),
    .btn_l      (btn_l),
    .btn_r      (btn_r),
    .calc_done  (calc_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .calc_start (calc_start),
    .edit_val   (edit_val),
    .cursor     (cursor),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic [4:0] b, input logic done);
    int step;
    if (ms == 0 || ms == 2) begin
      step = 10 ** cur;
      if (b[4])      ms = ms + 1;
      else if (b[3]) cur = (cur + 1) % 4;
      else if (b[2]) cur = (cur + 3) % 4;
      else if (b[1]) begin if (ev + step <= MAX_MAG) ev = ev + step; end
      else if (b[0]) begin if (ev - step >= -MAX_MAG) ev = ev - step; end
    end else if (ms == 1) begin
      ms = 2; ev = 0; cur = 0;
    end else if (ms == 3) ms = 4;
    else if (ms == 4) ms = 5;
    else if (ms == 5) begin if (done) ms = 6; end
    else if (ms == 6) begin
      if (b[4]) begin ms = 0; ev = 0; cur = 0; end
    end
  endtask

  task automatic check_all();
    bit we;
    we = (ms == 1 || ms == 3);
    chk_val("state",      int'(state), ms);
    chk_val("edit_val",   int'($signed(edit_val)), ev);
    chk_val("cursor",     int'(cursor), cur);
    chk_val("mem_we",     int'(mem_we), int'(we));
    chk_val("mem_addr",   int'(mem_addr), int'(ms == 3));
    chk_val("mem_din",    int'(mem_din), we ? (ev & 32'hFFFF) : 0);
    chk_val("calc_start", int'(calc_start), int'(ms == 4));
  endtask

  // Called at a falling edge; applies inputs across one rising edge.
  task automatic cyc(input logic [4:0] b, input logic done);
    {btn_c, btn_l, btn_r, btn_u, btn_d} = b;
    calc_done = done;
    @(posedge clk);
    model_step(b, done);
    @(negedge clk);
    {btn_c, btn_l, btn_r, btn_u, btn_d} = B0;
    calc_done = 1'b0;
    check_all();
  endtask

  task automatic press(input logic [4:0] b, input int n);
    for (int i = 0; i < n; i++) cyc(b, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle, released on the next falling edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    ms = 0; ev = 0; cur = 0;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    logic [4:0] b;
    logic       d;
    reset = 1'b1;
    {btn_c, btn_l, btn_r, btn_u, btn_d} = B0;
    calc_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // cursor left twice, up three times, right three times
    press(BL, 2);
    press(BU, 3);
    chk_val("dir_cursor2", int'(cursor), 2);
    chk_val("dir_val300",  int'($signed(edit_val)), 300);
    press(BR, 3);
    chk_val("dir_cursor3", int'(cursor), 3);

    // upper limit: 9500 at thousands, then hundreds
    do_reset();
    press(BR, 1);
    press(BU, 9);
    press(BR, 1);
    press(BU, 5);
    chk_val("dir_val9500", int'($signed(edit_val)), 9500);
    press(BL, 1);
    press(BU, 1);
    chk_val("dir_hold9500", int'($signed(edit_val)), 9500);
    press(BR, 1);
    press(BU, 5);
    chk_val("dir_hold9900", int'($signed(edit_val)), 9900);

    // lower limit: -9995 then five downs at ones
    do_reset();
    press(BR, 1); press(BD, 9);
    press(BR, 1); press(BD, 9);
    press(BR, 1); press(BD, 9);
    press(BR, 1); press(BD, 5);
    chk_val("dir_valm9995", int'($signed(edit_val)), -9995);
    press(BD, 5);
    chk_val("dir_valm9999", int'($signed(edit_val)), -9999);

    // A=123, B=-45 through the full transaction
    do_reset();
    press(BL, 2); press(BU, 1);
    press(BR, 1); press(BU, 2);
    press(BR, 1); press(BU, 3);
    cyc(BC, 1'b0);
    chk_val("wrA_we",   int'(mem_we), 1);
    chk_val("wrA_addr", int'(mem_addr), 0);
    chk_val("wrA_din",  int'(mem_din), 123);
    cyc(B0, 1'b0);
    press(BL, 1); press(BD, 4);
    press(BR, 1); press(BD, 5);
    cyc(BC, 1'b0);
    chk_val("wrB_we",   int'(mem_we), 1);
    chk_val("wrB_addr", int'(mem_addr), 1);
    chk_val("wrB_din",  int'(mem_din), 'hFFD3);
    cyc(B0, 1'b0);
    chk_val("start_pulse", int'(calc_start), 1);
    cyc(BC | BU, 1'b0);
    cyc(B0, 1'b0);
    chk_val("wait_state", int'(state), 5);
    cyc(B0, 1'b1);
    chk_val("show_state", int'(state), 6);
    press(BU, 2);
    cyc(BC, 1'b0);
    chk_val("back_editA", int'(state), 0);

    // simultaneous up+left, then reset during WAIT
    cyc(BU | BL, 1'b0);
    chk_val("prio_cursor", int'(cursor), 1);
    chk_val("prio_val",    int'($signed(edit_val)), 0);
    cyc(BC, 1'b0); cyc(B0, 1'b0); cyc(BC, 1'b0); cyc(B0, 1'b0); cyc(B0, 1'b0);
    chk_val("pre_reset_wait", int'(state), 5);
    do_reset();
    cyc(B0, 1'b1);
    chk_val("late_done", int'(state), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      b[4] = ($urandom_range(0, 11) == 0);
      b[3] = ($urandom_range(0, 4) == 0);
      b[2] = ($urandom_range(0, 4) == 0);
      b[1] = ($urandom_range(0, 2) == 0);
      b[0] = ($urandom_range(0, 2) == 0);
      d    = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc(b, d);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/operand_entry_ctrl.md
OPERAND_ENTRY_CTRL -- requirements
Module: operand_entry_ctrl

Interface
REQ-001 The module SHALL have parameter MAX_MAG, default 9999, giving the maximum operand magnitude (signed decimal).
REQ-002 The module SHALL have parameter DW, default 16, giving the operand width (two's complement).
REQ-003 The module SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have ports btn_c, btn_u, btn_d, btn_l, btn_r  input  1 each  debounced single-cycle button pulses.
REQ-006 The module SHALL have port calc_done  input  1  single-cycle pulse from the arithmetic unit, result valid.
REQ-007 The module SHALL have port mem_we  output  1  operand-store write strobe.
REQ-008 The module SHALL have port mem_addr  output  1  operand-store address (0 = A, 1 = B).
REQ-009 The module SHALL have port mem_din  output  DW  operand-store write data.
REQ-010 The module SHALL have port calc_start  output  1  single-cycle start pulse to the arithmetic unit.
REQ-011 The module SHALL have port edit_val  output  DW  operand currently being edited, for display.
REQ-012 The module SHALL have port cursor  output  2  selected digit (0 ones, 1 tens, 2 hundreds, 3 thousands).
REQ-013 The module SHALL have port state  output  3  current FSM state code, for display muxing.

Function
REQ-014 The FSM SHALL have states EDIT_A=0, WR_A=1, EDIT_B=2, WR_B=3, START=4, WAIT=5, SHOW=6; code 7 is illegal and SHALL return to EDIT_A on the next cycle.
REQ-015 Only one button SHALL be acted on per cycle; priority C > L > R > U > D; lower-priority pulses in the same cycle are discarded.
REQ-016 In EDIT_A/EDIT_B: btn_l SHALL set cursor to cursor+1 mod 4 (3 wraps to 0); btn_r SHALL set cursor to cursor-1 mod 4 (0 wraps to 3).
REQ-017 In EDIT_A/EDIT_B: btn_u SHALL add 10^cursor to edit_val only if the result is <= MAX_MAG; otherwise edit_val is unchanged (no saturation, no wrap).
REQ-018 In EDIT_A/EDIT_B: btn_d SHALL subtract 10^cursor only if the result is >= -MAX_MAG; otherwise edit_val is unchanged.
REQ-019 Range checks SHALL use a sign-extended (DW+1)-bit comparison so no intermediate overflow affects the decision.
REQ-020 btn_c in EDIT_A SHALL go to WR_A; in EDIT_B it SHALL go to WR_B.
REQ-021 WR_A SHALL assert mem_we=1, mem_addr=0, mem_din=edit_val for exactly one cycle, then enter EDIT_B with edit_val=0 and cursor=0.
REQ-022 WR_B SHALL assert mem_we=1, mem_addr=1, mem_din=edit_val for exactly one cycle, then enter START.
REQ-023 START SHALL assert calc_start for exactly one cycle, then enter WAIT.
REQ-024 WAIT SHALL hold until calc_done=1, then enter SHOW on the next edge; all buttons SHALL be ignored in WR_A, WR_B, START and WAIT.
REQ-025 A calc_done pulse outside WAIT SHALL be ignored.
REQ-026 In SHOW, btn_c SHALL return to EDIT_A with edit_val=0 and cursor=0; other buttons are ignored.
REQ-027 mem_we and calc_start SHALL be registered outputs, 0 in every state other than those named above.
REQ-028 mem_din SHALL equal 0 whenever mem_we=0.

Reset
REQ-029 Asserting reset at any time, including during a write or WAIT, SHALL immediately force state=EDIT_A, edit_val=0, cursor=0, mem_we=0, mem_addr=0, mem_din=0, calc_start=0.
REQ-030 The first rising edge after reset deassertion SHALL process inputs normally.

Verification
REQ-031 Reset; pulse btn_l x2; pulse btn_u x3 -> cursor=2, edit_val=300; btn_r x3 -> cursor=3.
REQ-032 In EDIT_A with edit_val=9500 and cursor=3, pulse btn_u -> edit_val stays 9500; with cursor=2, pulse btn_u x5 -> edit_val=9999 is never exceeded (stays 9900).
REQ-033 edit_val=-9995, cursor=0, pulse btn_d x5 -> edit_val=-9999 then unchanged.
REQ-034 A=123, B=-45 entered and confirmed -> one cycle each of mem_we with (0,123) then (1,0xFFD3), then one calc_start pulse; state=WAIT until calc_done, then SHOW.
REQ-035 btn_u and btn_l pulsed in the same cycle -> only cursor changes; reset asserted during WAIT -> state=EDIT_A; a later calc_done has no effect.
